// File: rtl/minmax_window.sv
// Windowed min/max reducer: folds WIN upstream (min,max) pairs into one
// registered result with a valid/ready handshake on both sides.
module minmax_window #(
  parameter int DATA = 8,
  parameter int WIN  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] in_min,
  input  logic [DATA-1:0] in_max,
  input  logic            clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_min,
  output logic [DATA-1:0] out_max,
  output logic            out_swap
);

  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  typedef enum logic [1:0] {
    EMPTY,
    ACCUM,
    FULL
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [DATA-1:0] acc_min;
  logic [DATA-1:0] acc_max;
  logic            swap;

  logic            accept;
  logic            pair_swap;
  logic [DATA-1:0] nxt_min;
  logic [DATA-1:0] nxt_max;
  logic            nxt_swap;

  assign in_ready  = !rst && !clear
                   && (state != FULL || out_ready);
  assign accept    = in_valid && in_ready;
  assign pair_swap = in_min > in_max;

  // Strict compares so ties keep the accumulated value
  assign nxt_min  = (in_min < acc_min) ? in_min : acc_min;
  assign nxt_max  = (in_max > acc_max) ? in_max : acc_max;
  assign nxt_swap = swap | pair_swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      count     <= '0;
      acc_min   <= '0;
      acc_max   <= '0;
      swap      <= 1'b0;
      out_valid <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
      out_swap  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (clear) begin
            count <= '0;
            swap  <= 1'b0;
          end else if (accept) begin
            acc_min <= in_min;
            acc_max <= in_max;
            swap    <= pair_swap;
            count   <= CW'(1);
            state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (clear) begin
            count <= '0;
            swap  <= 1'b0;
            state <= EMPTY;
          end else if (accept) begin
            if (count == LAST) begin
              out_min   <= nxt_min;
              out_max   <= nxt_max;
              out_swap  <= nxt_swap;
              out_valid <= 1'b1;
              count     <= '0;
              swap      <= 1'b0;
              state     <= FULL;
            end else begin
              acc_min <= nxt_min;
              acc_max <= nxt_max;
              swap    <= nxt_swap;
              count   <= count + CW'(1);
            end
          end
        end
        FULL: begin
          // A retiring result may overlap the first pair of the next window
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              acc_min <= in_min;
              acc_max <= in_max;
              swap    <= pair_swap;
              count   <= CW'(1);
              state   <= ACCUM;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          count     <= '0;
          swap      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
